// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface program_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: framed byte stream -> 16-bit instruction memory writes,
// holding the CPU in reset until a checksum-valid program is loaded.
module program_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              pc_reset,
    input  logic              start,
    program_loader_if.slave   bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [7:0]        acc_q;
    logic [7:0]        hi_q;
    logic [15:0]       n_q;
    logic [ADDR_W:0]   cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [15:0]       wdata_q;

    logic              rx;
    logic              fire;
    logic              launch;
    logic [15:0]       n_in;
    logic [16:0]       cnt_nxt;
    logic              last;

    assign fire    = bus.in_valid & rx;
    assign n_in    = {hi_q, bus.in_data};
    assign cnt_nxt = 17'(cnt_q) + 17'd1;
    assign last    = (cnt_nxt == {1'b0, n_q});

    always_ff @(posedge clk or negedge pc_reset) begin
        if (!pc_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_d = S_HDR_HI;
            end
            S_HDR_HI: begin
                if (fire) state_d = S_HDR_LO;
            end
            S_HDR_LO: begin
                if (fire) begin
                    if (n_in == 16'd0) begin
                        state_d = S_CHECK;
                    end else if ({1'b0, n_in} > CAP) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (fire) state_d = S_DATA_LO;
            end
            S_DATA_LO: begin
                if (fire) state_d = last ? S_CHECK : S_DATA_HI;
            end
            S_CHECK: begin
                if (fire) begin
                    state_d = (bus.in_data == acc_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx       = 1'b0;
        launch   = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        unique case (state_q)
            S_HDR_HI, S_HDR_LO, S_DATA_HI, S_DATA_LO, S_CHECK: rx = 1'b1;
            S_IDLE: launch = start;
            S_DONE: begin
                launch   = start;
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            S_ERROR: begin
                launch = start;
                error  = 1'b1;
            end
            default: rx = 1'b0;
        endcase
    end

    // Datapath: checksum, word assembly and the registered write port.
    always_ff @(posedge clk or negedge pc_reset) begin
        if (!pc_reset) begin
            acc_q   <= '0;
            hi_q    <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= 1'b0;
            if (launch) begin
                acc_q <= '0;
                cnt_q <= '0;
            end
            if (fire && state_q != S_CHECK) begin
                acc_q <= acc_q ^ bus.in_data;
            end
            if (fire && (state_q == S_HDR_HI || state_q == S_DATA_HI)) begin
                hi_q <= bus.in_data;
            end
            if (fire && state_q == S_HDR_LO) begin
                n_q <= n_in;
            end
            if (fire && state_q == S_DATA_LO) begin
                we_q    <= 1'b1;
                waddr_q <= cnt_q[ADDR_W-1:0];
                wdata_q <= n_in;
                cnt_q   <= cnt_nxt[ADDR_W:0];
            end
        end
    end

    assign bus.in_ready   = rx;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = rx;
    assign words_loaded   = cnt_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued by the
// stimulus and popped by a monitor whenever the write strobe is seen.
module tb_program_loader;

    localparam int AW = 8;

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    logic          clk = 1'b0;
    logic          pc_reset = 1'b0;
    logic          start = 1'b0;
    logic          cpu_hold, busy, done, error;
    logic [AW:0]   words_loaded;

    int n_chk = 0;
    int n_fail = 0;
    wr_t exp_q[$];
    logic prev_we = 1'b0;

    program_loader_if #(.ADDR_W(AW)) bus_if ();

    program_loader #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .pc_reset     (pc_reset),
        .start        (start),
        .bus          (bus_if),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pc_reset && bus_if.imem_we) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         bus_if.imem_addr, bus_if.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus_if.imem_addr), 32'(e.a));
                check("wr_data", 32'(bus_if.imem_wdata), 32'(e.d));
            end
            check("strobe_width", 32'(prev_we), 32'd0);
        end
        prev_we = pc_reset & bus_if.imem_we;
    end

    task automatic exp_wr(input int a, input logic [15:0] d);
        wr_t w;
        w.a = a[AW-1:0];
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
        int t;
        if (gap > 0) begin
            bus_if.in_valid = 1'b0;
            repeat (gap) begin
                start = pulse;
                @(posedge clk);
                #1;
            end
            start = 1'b0;
        end
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = b;
        t = 0;
        forever begin
            @(negedge clk);
            if (bus_if.in_ready) break;
            t++;
            if (t > 50) begin
                check("byte_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input int gmax, input bit pulse);
        foreach (bytes[i]) begin
            send_byte(bytes[i], (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0, pulse);
        end
        bus_if.in_valid = 1'b0;
    endtask

    task automatic status(input string nm, input logic d, input logic e,
                          input logic h, input int w);
        check({nm, "_done"}, 32'(done), 32'(d));
        check({nm, "_error"}, 32'(error), 32'(e));
        check({nm, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
        check({nm, "_words"}, 32'(words_loaded), 32'(w));
        check({nm, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic drain(input string nm);
        repeat (3) @(negedge clk);
        check({nm, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic std_frame(input logic [7:0] chk);
        do_start();
        exp_wr(0, 16'h1234);
        exp_wr(1, 16'hABCD);
        send_frame('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, chk}, 0, 1'b0);
    endtask

    initial begin
        logic [7:0] big[$];
        logic [7:0] x;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 8'h00;
        #1;
        check("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
        check("rst_we", 32'(bus_if.imem_we), 32'd0);
        check("rst_addr", 32'(bus_if.imem_addr), 32'd0);
        check("rst_wdata", 32'(bus_if.imem_wdata), 32'd0);
        status("rst", 1'b0, 1'b0, 1'b1, 0);
        repeat (2) @(posedge clk);
        #1 pc_reset = 1'b1;
        @(posedge clk);
        #1;

        // start with in_valid high in IDLE must not consume the byte
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 8'h77;
        std_frame(8'h42);
        status("good", 1'b1, 1'b0, 1'b0, 2);
        drain("good");

        std_frame(8'h43);
        status("badsum", 1'b0, 1'b1, 1'b1, 2);
        drain("badsum");

        do_start();
        send_frame('{8'h00, 8'h00, 8'h00}, 0, 1'b0);
        status("n0_ok", 1'b1, 1'b0, 1'b0, 0);
        drain("n0_ok");

        do_start();
        send_frame('{8'h00, 8'h00, 8'h01}, 0, 1'b0);
        status("n0_bad", 1'b0, 1'b1, 1'b1, 0);
        drain("n0_bad");

        do_start();
        send_frame('{8'h01, 8'h01}, 0, 1'b0);
        status("oversize", 1'b0, 1'b1, 1'b1, 0);
        check("oversize_in_ready", 32'(bus_if.in_ready), 32'd0);
        drain("oversize");

        big = '{8'h01, 8'h00};
        x = 8'h01;
        for (int i = 0; i < 256; i++) begin
            big.push_back(i[7:0]);
            big.push_back(~i[7:0]);
            x = x ^ i[7:0] ^ ~i[7:0];
            exp_wr(i, {i[7:0], ~i[7:0]});
        end
        big.push_back(x);
        do_start();
        send_frame(big, 0, 1'b0);
        status("full", 1'b1, 1'b0, 1'b0, 256);
        drain("full");

        do_start();
        exp_wr(0, 16'hBEEF);
        send_frame('{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50}, 3, 1'b1);
        status("gaps", 1'b1, 1'b0, 1'b0, 1);
        drain("gaps");

        do_start();
        check("restart_cpu_hold", 32'(cpu_hold), 32'd1);
        check("restart_words", 32'(words_loaded), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);

        exp_wr(0, 16'h1234);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0);
        send_byte(8'hAB, 0, 1'b0);
        #2 pc_reset = 1'b0;
        bus_if.in_valid = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(bus_if.in_ready), 32'd0);
        check("mid_rst_we", 32'(bus_if.imem_we), 32'd0);
        check("mid_rst_addr", 32'(bus_if.imem_addr), 32'd0);
        status("mid_rst", 1'b0, 1'b0, 1'b1, 0);
        @(posedge clk);
        #1 pc_reset = 1'b1;
        drain("mid_rst");

        std_frame(8'h42);
        status("reload", 1'b1, 1'b0, 1'b0, 2);
        drain("reload");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
